// File: rtl/n64_receive_byte.sv
// N64 one-wire link receiver: times low pulses on the synchronized line,
// shifts in 8 bits MSB first and strobes byte_valid for one cycle.
module n64_receive_byte #(
    parameter int CYCLES_PER_US = 50,
    parameter int TIMEOUT_US    = 8,
    parameter int GLITCH_CYCLES = 5
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       n64d,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       receiving,
    output logic       error
);

    localparam int TIMEOUT_CNT = TIMEOUT_US * CYCLES_PER_US;
    localparam int CW          = $clog2(TIMEOUT_CNT + 1);

    // cnt holds (pulse length - 1) in the cycle the closing edge is seen
    localparam logic [CW-1:0] TMO_LIM    = CW'(TIMEOUT_CNT);
    localparam logic [CW-1:0] GLITCH_LIM = CW'(GLITCH_CYCLES - 1);
    localparam logic [CW-1:0] ONE_LIM    = CW'(2 * CYCLES_PER_US - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t          state, state_n;
    logic            sync1, sync2, line_d;
    logic            fall, rise;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      byte_out_n;
    logic            byte_valid_n, receiving_n, error_n;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= n64d;
            sync2  <= sync1;
            line_d <= sync2;
        end
    end

    assign fall = line_d & ~sync2;
    assign rise = ~line_d & sync2;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (fall || rise)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            receiving  <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_out   <= byte_out_n;
            byte_valid <= byte_valid_n;
            receiving  <= receiving_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        byte_out_n   = byte_out;
        byte_valid_n = 1'b0;
        receiving_n  = receiving;
        error_n      = 1'b0;
        if (!enable) begin
            state_n     = IDLE;
            bit_idx_n   = '0;
            receiving_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_idx_n = '0;
                    if (fall) begin
                        state_n     = LOW;
                        receiving_n = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        if (cnt < GLITCH_LIM) begin
                            if (bit_idx == 4'd0) begin
                                state_n     = IDLE;
                                receiving_n = 1'b0;
                            end else begin
                                state_n = HIGH;
                            end
                        end else begin
                            shreg_n   = {shreg[6:0], (cnt < ONE_LIM)};
                            bit_idx_n = bit_idx + 4'd1;
                            state_n   = HIGH;
                        end
                    end else if (cnt == TMO_LIM) begin
                        error_n     = 1'b1;
                        receiving_n = 1'b0;
                        bit_idx_n   = '0;
                        state_n     = IDLE;
                    end
                end
                HIGH: begin
                    if (bit_idx == 4'd8) begin
                        byte_out_n   = shreg;
                        byte_valid_n = 1'b1;
                        receiving_n  = 1'b0;
                        bit_idx_n    = '0;
                        state_n      = IDLE;
                    end else if (fall) begin
                        state_n = LOW;
                    end else if (cnt == TMO_LIM) begin
                        error_n     = 1'b1;
                        receiving_n = 1'b0;
                        bit_idx_n   = '0;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
